// File: rtl/axi_ar_boundary_protect.sv
// AXI read-address splitter: INCR bursts that cross a 4 KB page are issued downstream as two
// bursts, and one "split" flag per accepted burst is pushed to the R-channel merger's flag FIFO.
module axi_ar_boundary_protect (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic [3:0]  s_axi_arcache,
  input  logic [2:0]  s_axi_arprot,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic [3:0]  m_axi_arcache,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic        rd_across_boundary_fifo_wen,
  output logic        rd_across_boundary_fifo_din,
  input  logic        rd_across_boundary_fifo_full_n
);

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;

  state_t      state;
  logic        split_q;
  logic [31:0] addr2_q;
  logic [7:0]  len2_q;

  logic [9:0]  word_idx;
  logic [10:0] beats_to_boundary;
  logic [8:0]  total_beats;
  logic        split;
  logic [7:0]  first_len;
  logic [7:0]  second_len;
  logic [31:0] second_addr;
  logic        accept;
  logic        m_handshake;

  // Beats left in the current 4 KB page (1..1024) versus beats requested (1..256).
  assign word_idx          = s_axi_araddr[11:2];
  assign beats_to_boundary = 11'd1024 - {1'b0, word_idx};
  assign total_beats       = {1'b0, s_axi_arlen} + 9'd1;
  assign split             = (s_axi_arburst == BURST_INCR) &&
                             ({2'b00, total_beats} > beats_to_boundary);

  // Only meaningful when split: both lengths are then below 256 beats.
  assign first_len   = 8'(beats_to_boundary - 11'd1);
  assign second_len  = 8'({2'b00, total_beats} - beats_to_boundary - 11'd1);
  assign second_addr = {s_axi_araddr[31:12] + 20'd1, 12'h000};

  assign s_axi_arready               = (state == IDLE) && rd_across_boundary_fifo_full_n;
  assign accept                      = s_axi_arvalid && s_axi_arready && rst_n;
  assign rd_across_boundary_fifo_wen = accept;
  assign rd_across_boundary_fifo_din = split;
  assign m_handshake                 = m_axi_arvalid && m_axi_arready;

  // NOTE: every register here is small control/datapath state, so all of it takes the async
  // reset; m_axi_arvalid must drop the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
      m_axi_arcache <= '0;
      m_axi_arprot  <= '0;
      m_axi_arvalid <= 1'b0;
      split_q       <= 1'b0;
      addr2_q       <= '0;
      len2_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (accept) begin
            m_axi_araddr  <= s_axi_araddr;
            m_axi_arlen   <= split ? first_len : s_axi_arlen;
            m_axi_arsize  <= s_axi_arsize;
            m_axi_arburst <= s_axi_arburst;
            m_axi_arcache <= s_axi_arcache;
            m_axi_arprot  <= s_axi_arprot;
            m_axi_arvalid <= 1'b1;
            split_q       <= split;
            addr2_q       <= second_addr;
            len2_q        <= second_len;
            state         <= SEND0;
          end
        end
        SEND0: begin
          if (m_handshake) begin
            if (split_q) begin
              m_axi_araddr <= addr2_q;
              m_axi_arlen  <= len2_q;
              state        <= SEND1;
            end else begin
              m_axi_arvalid <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        SEND1: begin
          if (m_handshake) begin
            m_axi_arvalid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ar_boundary_protect.sv
// Self-checking bench for axi_ar_boundary_protect: directed plan cases plus randomized bursts
// checked against a page-arithmetic reference model and an expected-AR queue.
module tb_axi_ar_boundary_protect;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } ar_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = 3'b010;
  logic [1:0]  s_axi_arburst = 2'b01;
  logic [3:0]  s_axi_arcache = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic        rd_across_boundary_fifo_wen;
  logic        rd_across_boundary_fifo_din;
  logic        rd_across_boundary_fifo_full_n = 1'b1;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  accept_count = 0;
  int  last_acc_cyc = 0;
  bit  last_flag = 1'b0;
  bit  rand_mode = 1'b0;
  bit  fixed_rdy = 1'b1;
  bit  fixed_full = 1'b1;
  bit  stall_prev = 1'b0;
  ar_t stall_ar;
  ar_t exp_q[$];
  ar_t obs_q[$];

  axi_ar_boundary_protect dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .s_axi_araddr                   (s_axi_araddr),
    .s_axi_arlen                    (s_axi_arlen),
    .s_axi_arsize                   (s_axi_arsize),
    .s_axi_arburst                  (s_axi_arburst),
    .s_axi_arcache                  (s_axi_arcache),
    .s_axi_arprot                   (s_axi_arprot),
    .s_axi_arvalid                  (s_axi_arvalid),
    .s_axi_arready                  (s_axi_arready),
    .m_axi_araddr                   (m_axi_araddr),
    .m_axi_arlen                    (m_axi_arlen),
    .m_axi_arsize                   (m_axi_arsize),
    .m_axi_arburst                  (m_axi_arburst),
    .m_axi_arcache                  (m_axi_arcache),
    .m_axi_arprot                   (m_axi_arprot),
    .m_axi_arvalid                  (m_axi_arvalid),
    .m_axi_arready                  (m_axi_arready),
    .rd_across_boundary_fifo_wen    (rd_across_boundary_fifo_wen),
    .rd_across_boundary_fifo_din    (rd_across_boundary_fifo_din),
    .rd_across_boundary_fifo_full_n (rd_across_boundary_fifo_full_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready and FIFO full_n change 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (rand_mode) begin
      m_axi_arready                  = ($urandom_range(0, 9) < 7);
      rd_across_boundary_fifo_full_n = ($urandom_range(0, 9) < 8);
    end else begin
      m_axi_arready                  = fixed_rdy;
      rd_across_boundary_fifo_full_n = fixed_full;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: page arithmetic on plain integers, one or two expected ARs per burst.
  function automatic bit model_accept(input ar_t up);
    longint unsigned a64;
    longint unsigned word;
    longint unsigned room;
    longint unsigned total;
    ar_t first;
    ar_t second;
    a64   = up.addr;
    word  = (a64 % 4096) / 4;
    room  = 1024 - word;
    total = longint'(up.len) + 1;
    if (up.burst == 2'b01 && total > room) begin
      first       = up;
      first.len   = 8'(room - 1);
      second      = up;
      second.addr = 32'(((a64 / 4096 + 1) * 4096) % 64'h1_0000_0000);
      second.len  = 8'(total - room - 1);
      exp_q.push_back(first);
      exp_q.push_back(second);
      return 1'b1;
    end
    exp_q.push_back(up);
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_m_arvalid", m_axi_arvalid, 0);
      check("rst_m_araddr", m_axi_araddr, 0);
      check("rst_m_arlen", m_axi_arlen, 0);
      check("rst_sideband", {m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot}, 0);
      check("rst_fifo_wen", rd_across_boundary_fifo_wen, 0);
      check("rst_s_arready", s_axi_arready, rd_across_boundary_fifo_full_n);
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      bit  exp_ready;
      ar_t up;
      exp_ready = (exp_q.size() == 0) && rd_across_boundary_fifo_full_n;
      check("s_arready", s_axi_arready, exp_ready);
      check("m_arvalid", m_axi_arvalid, exp_q.size() != 0);
      check("fifo_wen", rd_across_boundary_fifo_wen, s_axi_arvalid && exp_ready);
      if (stall_prev) begin
        check("stall_addr", m_axi_araddr, stall_ar.addr);
        check("stall_len", m_axi_arlen, stall_ar.len);
        check("stall_side", {m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot},
              {stall_ar.size, stall_ar.burst, stall_ar.cache, stall_ar.prot});
      end
      if (m_axi_arvalid && m_axi_arready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ar", 1, 0);
        end else begin
          ar_t e;
          e = exp_q.pop_front();
          check("ar_addr", m_axi_araddr, e.addr);
          check("ar_len", m_axi_arlen, e.len);
          check("ar_side", {m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot},
                {e.size, e.burst, e.cache, e.prot});
        end
        up.addr  = m_axi_araddr;
        up.len   = m_axi_arlen;
        up.size  = m_axi_arsize;
        up.burst = m_axi_arburst;
        up.cache = m_axi_arcache;
        up.prot  = m_axi_arprot;
        obs_q.push_back(up);
      end
      if (s_axi_arvalid && exp_ready) begin
        bit flag;
        up.addr  = s_axi_araddr;
        up.len   = s_axi_arlen;
        up.size  = s_axi_arsize;
        up.burst = s_axi_arburst;
        up.cache = s_axi_arcache;
        up.prot  = s_axi_arprot;
        flag = model_accept(up);
        check("fifo_din", rd_across_boundary_fifo_din, flag);
        last_flag    = rd_across_boundary_fifo_din;
        last_acc_cyc = cyc;
        accept_count++;
      end
      stall_prev = m_axi_arvalid && !m_axi_arready;
      if (stall_prev) begin
        stall_ar.addr  = m_axi_araddr;
        stall_ar.len   = m_axi_arlen;
        stall_ar.size  = m_axi_arsize;
        stall_ar.burst = m_axi_arburst;
        stall_ar.cache = m_axi_arcache;
        stall_ar.prot  = m_axi_arprot;
      end
    end
  end

  // All driving happens 1 time unit after a rising edge.
  task automatic send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
    int n0;
    int waited;
    s_axi_araddr  = a;
    s_axi_arlen   = l;
    s_axi_arburst = b;
    s_axi_arcache = 4'($urandom);
    s_axi_arprot  = 3'($urandom);
    s_axi_arvalid = 1'b1;
    n0 = accept_count;
    waited = 0;
    while (accept_count == n0 && waited < 500) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (accept_count == n0) check("accept_timeout", 0, 1);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (exp_q.size() != 0) check("idle_timeout", exp_q.size(), 0);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [7:0] l,
                          input logic [1:0] b, input int n_exp,
                          input logic [31:0] a0, input logic [7:0] l0,
                          input logic [31:0] a1, input logic [7:0] l1, input bit flag);
    int base;
    base = obs_q.size();
    send(a, l, b);
    wait_idle();
    check({tag, "_count"}, obs_q.size() - base, n_exp);
    check({tag, "_flag"}, last_flag, flag);
    if (obs_q.size() > base) begin
      check({tag, "_addr0"}, obs_q[base].addr, a0);
      check({tag, "_len0"}, obs_q[base].len, l0);
    end
    if (n_exp == 2 && obs_q.size() > base + 1) begin
      check({tag, "_addr1"}, obs_q[base+1].addr, a1);
      check({tag, "_len1"}, obs_q[base+1].len, l1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;
    int n0;
    // Upstream valid is asserted during reset and must be ignored.
    s_axi_araddr  = 32'h0000_1FF0;
    s_axi_arlen   = 8'd7;
    s_axi_arvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_axi_arvalid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("incr_nosplit", 32'h0000_1000, 8'd15, 2'b01, 1, 32'h0000_1000, 8'd15, '0, '0, 1'b0);
    directed("incr_split8", 32'h0000_1FF0, 8'd7, 2'b01, 2, 32'h0000_1FF0, 8'd3,
             32'h0000_2000, 8'd3, 1'b1);
    directed("incr_split256", 32'h0000_1FFC, 8'd255, 2'b01, 2, 32'h0000_1FFC, 8'd0,
             32'h0000_2000, 8'd254, 1'b1);
    directed("incr_exact", 32'h0000_1C00, 8'd255, 2'b01, 1, 32'h0000_1C00, 8'd255, '0, '0, 1'b0);
    directed("incr_wrap32", 32'hFFFF_FFF8, 8'd3, 2'b01, 2, 32'hFFFF_FFF8, 8'd1,
             32'h0000_0000, 8'd1, 1'b1);
    directed("wrap_burst", 32'h0000_1FF0, 8'd7, 2'b10, 1, 32'h0000_1FF0, 8'd7, '0, '0, 1'b0);
    directed("fixed_burst", 32'h0000_1FFC, 8'd3, 2'b00, 1, 32'h0000_1FFC, 8'd3, '0, '0, 1'b0);

    // Throughput with downstream ready held high.
    send(32'h0000_1000, 8'd15, 2'b01);
    c1 = last_acc_cyc;
    send(32'h0000_2000, 8'd3, 2'b01);
    check("tput_unsplit", last_acc_cyc - c1, 2);
    wait_idle();
    send(32'h0000_1FF0, 8'd7, 2'b01);
    c1 = last_acc_cyc;
    send(32'h0000_2FF8, 8'd7, 2'b01);
    check("tput_split", last_acc_cyc - c1, 3);
    wait_idle();

    // Flag FIFO full: no accept and no write until full_n returns.
    fixed_full    = 1'b0;
    s_axi_araddr  = 32'h0000_3FF8;
    s_axi_arlen   = 8'd5;
    s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1;
    n0 = accept_count;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("full_arready", s_axi_arready, 0);
      check("full_wen", rd_across_boundary_fifo_wen, 0);
      @(posedge clk);
      #1;
    end
    fixed_full = 1'b1;
    #2;
    check("unfull_arready", s_axi_arready, 1);
    check("unfull_wen", rd_across_boundary_fifo_wen, 1);
    check("unfull_din", rd_across_boundary_fifo_din, 1);
    @(posedge clk);
    #1;
    s_axi_arvalid = 1'b0;
    check("unfull_accepted", accept_count - n0, 1);
    wait_idle();

    // Downstream stall in SEND0: outputs hold.
    fixed_rdy = 1'b0;
    send(32'h0000_5000, 8'd31, 2'b01);
    for (int i = 0; i < 5; i++) begin
      #2;
      check("stall0_valid", m_axi_arvalid, 1);
      check("stall0_addr", m_axi_araddr, 32'h0000_5000);
      check("stall0_len", m_axi_arlen, 8'd31);
      @(posedge clk);
      #1;
    end
    fixed_rdy = 1'b1;
    wait_idle();

    // Reset while the second half of a split burst is pending.
    fixed_rdy = 1'b0;
    send(32'h0000_6FF0, 8'd7, 2'b01);
    fixed_rdy = 1'b1;
    @(posedge clk);
    #1;
    fixed_rdy = 1'b0;
    #2;
    check("send1_valid", m_axi_arvalid, 1);
    check("send1_addr", m_axi_araddr, 32'h0000_7000);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", m_axi_arvalid, 0);
    check("midrst_addr", m_axi_araddr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fixed_rdy = 1'b1;
    #2;
    check("midrst_idle_ready", s_axi_arready, 1);
    @(posedge clk);
    #1;

    // Randomized bursts, biased toward page ends, with random ready and full_n.
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      logic [31:0] addr;
      int          pick;
      logic [1:0]  burst;
      r = $urandom;
      pick = $urandom_range(0, 2);
      if (pick == 0)      addr = r;
      else if (pick == 1) addr = {r[31:12], 2'b11, r[9:0]};
      else                addr = {20'hFFFFF, 2'b11, r[9:0]};
      pick = $urandom_range(0, 19);
      burst = (pick < 2) ? 2'b00 : (pick < 5) ? 2'b10 : 2'b01;
      send(addr, 8'($urandom), burst);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_mode = 1'b0;
    fixed_rdy = 1'b1;
    fixed_full = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
